// File: rtl/seg_scan_pkg.sv
// Shared seven-segment definitions for the display encoder and the scan decoder.
// Patterns are active-low, bit 6 = g ... bit 0 = a.
package seg_scan_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Returns {legal, value}; value is 0 when the pattern is not a hex glyph.
  function automatic logic [4:0] seg_to_hex(input logic [6:0] seg_pat);
    logic [4:0] res;
    res = 5'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg_pat == HEX_SEG[i]) res = {1'b1, 4'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/seg_dwell_filter.sv
// Registers the scan bus, waits for a stable dwell on a single anode and
// emits one capture strobe per dwell; also flags entry into multi-anode drive.
module seg_dwell_filter
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int IDX_W         = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            seg,
  input  logic [NUM_DIGITS-1:0] an,
  output logic                  cap_strobe,
  output logic [IDX_W-1:0]      cap_idx,
  output logic [6:0]            cap_seg,
  output logic                  multi_evt
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  logic [6:0]            r_seg_q, r_seg_d;
  logic [NUM_DIGITS-1:0] r_an_q, r_an_d;
  logic [6:0]            p_seg_q, p_seg_d;
  logic [NUM_DIGITS-1:0] p_an_q, p_an_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  captured_q, captured_d;

  logic                  changed;
  logic [NUM_DIGITS-1:0] an_low, p_an_low;
  logic                  multi_now, multi_prev, one_hot;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg_q    <= SEG_BLANK;
      r_an_q     <= '1;
      p_seg_q    <= SEG_BLANK;
      p_an_q     <= '1;
      cnt_q      <= '0;
      captured_q <= 1'b0;
    end else begin
      r_seg_q    <= r_seg_d;
      r_an_q     <= r_an_d;
      p_seg_q    <= p_seg_d;
      p_an_q     <= p_an_d;
      cnt_q      <= cnt_d;
      captured_q <= captured_d;
    end
  end

  always_comb begin
    r_seg_d = seg;
    r_an_d  = an;
    p_seg_d = r_seg_q;
    p_an_d  = r_an_q;

    changed  = ({r_seg_q, r_an_q} != {p_seg_q, p_an_q});
    an_low   = ~r_an_q;
    p_an_low = ~p_an_q;
    // x & (x-1) is non-zero exactly when two or more bits are set
    multi_now  = (an_low & (an_low - NUM_DIGITS'(1))) != '0;
    multi_prev = (p_an_low & (p_an_low - NUM_DIGITS'(1))) != '0;
    one_hot    = (an_low != '0) && !multi_now;

    if (changed) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(SETTLE_CYCLES)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // The !changed term keeps a capture from picking up a sample that has
    // just moved while the counter still reflects the previous dwell.
    cap_strobe = one_hot && !changed && !captured_q &&
                 (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
    captured_d = changed ? 1'b0 : (captured_q | cap_strobe);

    cap_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an_low[i]) cap_idx = IDX_W'(i);
    end

    cap_seg   = r_seg_q;
    multi_evt = multi_now && !multi_prev;
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Rebuilds the displayed hex digits from a multiplexed active-low seg/an bus,
// reporting blanks, illegal glyphs, anode faults and complete scan frames.
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic                    frame_done,
  output logic                    bad_pattern,
  output logic                    multi_anode,
  output logic [ERR_W-1:0]        err_count
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic             cap_strobe;
  logic [IDX_W-1:0] cap_idx;
  logic [6:0]       cap_seg;
  logic             multi_evt;

  seg_dwell_filter #(
    .NUM_DIGITS    (NUM_DIGITS),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .IDX_W         (IDX_W)
  ) u_dwell (
    .clk        (clk),
    .reset      (reset),
    .seg        (seg),
    .an         (an),
    .cap_strobe (cap_strobe),
    .cap_idx    (cap_idx),
    .cap_seg    (cap_seg),
    .multi_evt  (multi_evt)
  );

  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    frame_done_q, frame_done_d;
  logic                    bad_q, bad_d;
  logic                    multi_q, multi_d;
  logic [ERR_W-1:0]        err_q, err_d;
  logic                    err_inc;
  logic [4:0]              dec;

  always_ff @(posedge clk) begin
    if (reset) begin
      digits_q     <= '0;
      valid_q      <= '0;
      blank_q      <= '0;
      seen_q       <= '0;
      frame_done_q <= 1'b0;
      bad_q        <= 1'b0;
      multi_q      <= 1'b0;
      err_q        <= '0;
    end else begin
      digits_q     <= digits_d;
      valid_q      <= valid_d;
      blank_q      <= blank_d;
      seen_q       <= seen_d;
      frame_done_q <= frame_done_d;
      bad_q        <= bad_d;
      multi_q      <= multi_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    digits_d     = digits_q;
    valid_d      = valid_q;
    blank_d      = blank_q;
    seen_d       = seen_q;
    frame_done_d = 1'b0;
    bad_d        = bad_q;
    multi_d      = multi_q;
    err_d        = err_q;
    err_inc      = 1'b0;
    dec          = seg_to_hex(cap_seg);

    if (cap_strobe) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (cap_idx == IDX_W'(i)) begin
          if (dec[4]) begin
            digits_d[4*i +: 4] = dec[3:0];
            valid_d[i]         = 1'b1;
            blank_d[i]         = 1'b0;
          end else if (cap_seg == SEG_BLANK) begin
            digits_d[4*i +: 4] = 4'h0;
            valid_d[i]         = 1'b0;
            blank_d[i]         = 1'b1;
          end else begin
            valid_d[i] = 1'b0;
            blank_d[i] = 1'b0;
            bad_d      = 1'b1;
            err_inc    = 1'b1;
          end
          seen_d[i] = 1'b1;
        end
      end
      if (&seen_d) begin
        frame_done_d = 1'b1;
        seen_d       = '0;
      end
    end

    // Capture and multi-anode entry are mutually exclusive, so one step suffices.
    if (multi_evt) begin
      multi_d = 1'b1;
      err_inc = 1'b1;
    end

    if (err_inc && (err_q != '1)) err_d = err_q + ERR_W'(1);
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign digit_blank = blank_q;
  assign frame_done  = frame_done_q;
  assign bad_pattern = bad_q;
  assign multi_anode = multi_q;
  assign err_count   = err_q;

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the multiplexed seven-segment driver: samples the active-low seg/an bus and rebuilds the eight displayed hex digits.
- Used in loopback self-check benches and on the board for on-chip display verification.
- Flags illegal segment patterns and anode faults, and pulses once per complete scan frame.

Parameters:
- NUM_DIGITS, 8, number of anodes/digits scanned
- SETTLE_CYCLES, 4, consecutive identical samples needed before a digit is captured (>=1)
- ERR_W, 8, width of the saturating error counter

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- seg  input  7  segment bus, active-low; seg[0]=a … seg[6]=g
- an  input  NUM_DIGITS  anode enables, active-low
- digits  output  4*NUM_DIGITS  recovered hex values; digit i in digits[4i+3:4i]
- digit_valid  output  NUM_DIGITS  digit i holds a legally decoded hex value
- digit_blank  output  NUM_DIGITS  digit i was last seen blank (seg=7'h7F)
- frame_done  output  1  one-cycle pulse when every digit has been captured since the last pulse
- bad_pattern  output  1  sticky: an undecodable segment pattern was captured
- multi_anode  output  1  sticky: more than one anode was low at the same time
- err_count  output  ERR_W  saturating count of bad-pattern captures plus multi-anode events

Behaviour:
- Reset: every output is 0; the internal sample registers load seg=7'h7F and an=all-ones; the stability counter, captured flag and seen-mask are cleared.
- Input stage: seg and an are registered every cycle (r_seg, r_an). No other logic uses the raw inputs.
- Stability counter:
  - Cleared when {r_seg, r_an} differs from the previous cycle.
  - Otherwise increments, saturating at SETTLE_CYCLES.
- Valid anode: r_an has exactly one zero bit, giving index idx.
  - No zero bits: idle; the counter still runs but no capture occurs.
  - Two or more zero bits: set multi_anode; increment err_count once per entry into that condition; no capture.
- Capture:
  - Occurs once per stable dwell, when the anode is valid, the counter equals SETTLE_CYCLES-1 and the captured flag is clear. The captured flag is then set; it clears when the counter clears.
  - Latency: if seg/an are held from edge t, the outputs change at edge t+SETTLE_CYCLES+1.
- Decode, r_seg written as g…a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Capture result, by pattern:
  - Legal hex pattern: digits[idx]=value, digit_valid[idx]=1, digit_blank[idx]=0.
  - 7'h7F: digit_blank[idx]=1, digit_valid[idx]=0, digits[idx]=0.
  - Any other pattern: digit_valid[idx]=0, digit_blank[idx]=0, digits[idx] unchanged; set bad_pattern; increment err_count.
- Frame detection:
  - Every capture, whatever its result, sets seen[idx].
  - When seen would become all-ones, frame_done pulses in the same cycle the capture is registered, and seen resets to 0.
  - Capturing the same digit twice does not advance the frame.
- err_count saturates at 2^ERR_W-1.
- Reset asserted mid-dwell or mid-frame returns every register to its reset value on the next edge; nothing captured before reset is retained.

Decomposition:
- Package seg_scan_pkg holds:
  - the 16 hex segment patterns as a constant array;
  - the SEG_BLANK constant (7'h7F);
  - a function seg_to_hex that returns {legal, value}.
- The encoder side of the display shares the same package.
- One sub-module, seg_dwell_filter: the input registers, stability counter, captured flag and anode one-hot check. It outputs cap_strobe, cap_idx, cap_seg and multi_evt.

Test Plan:
- Reset, then hold an=8'b11111110 and seg=1000000 for 10 cycles: digits[3:0]=0 and digit_valid=8'h01 exactly 5 edges after the first sample; no further capture during the hold.
- Scan 0..7 through anodes 0..7 with values 1,2,3,4,5,6,7,8, 8 cycles per digit: digits=32'h87654321, digit_valid=8'hFF, frame_done pulses exactly once, on the digit-7 capture.
- Hold an=8'b11111011 and seg=1111111 (blank): digit_blank[2]=1, digit_valid[2]=0, bad_pattern stays 0.
- Hold seg=1010101 on anode 4: bad_pattern=1, err_count=1, digits[19:16] unchanged, digit_valid[4]=0.
- Present an=8'b11110011 for 6 cycles: multi_anode=1, err_count increments by 1, no capture. Then toggle seg each cycle on a valid anode (SETTLE_CYCLES=4): no capture occurs.
- Assert reset for 1 cycle midway through a frame: all outputs read 0 on the next cycle; the next full frame produces exactly one frame_done.
